// File: rtl/alu_cmd_sequencer.sv
// Command-side controller for the 4-bit ALU.
// It accepts one command, sources operands from a 4x4 register file (R0 is
// hardwired to zero) and drives the ALU for exactly one cycle. It then
// captures the ALU outputs, optionally writes the result back, and presents
// a response.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. cmd_ready is high only in IDLE.
// rsp_valid is high only in RESP. Both decode purely from state, so neither
// depends combinationally on the opposite side of its channel.
module alu_cmd_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_ra,
    input  logic [1:0]       cmd_rb,
    input  logic [1:0]       cmd_rd,
    input  logic [3:0]       cmd_imm,
    input  logic             cmd_use_imm,
    input  logic             cmd_wb,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    input  logic [1:0]       rf_addr,
    output logic [3:0]       rf_data,
    output logic [CNT_W-1:0] cmd_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Latched command fields.
    logic [2:0] op_l;
    logic [1:0] ra_l;
    logic [1:0] rb_l;
    logic [1:0] rd_l;
    logic [3:0] imm_l;
    logic       use_imm_l;
    logic       wb_l;

    // Register file. Entry 0 is never written and is also masked on read.
    logic [3:0] regs [4];

    logic cmd_fire;
    logic rsp_fire;
    logic wr_en;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign wr_en    = (state == EXEC) && wb_l && (rd_l != 2'd0);

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = EXEC;
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Capture the command fields on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_l      <= 3'd0;
            ra_l      <= 2'd0;
            rb_l      <= 2'd0;
            rd_l      <= 2'd0;
            imm_l     <= 4'd0;
            use_imm_l <= 1'b0;
            wb_l      <= 1'b0;
        end else if (cmd_fire) begin
            op_l      <= cmd_op;
            ra_l      <= cmd_ra;
            rb_l      <= cmd_rb;
            rd_l      <= cmd_rd;
            imm_l     <= cmd_imm;
            use_imm_l <= cmd_use_imm;
            wb_l      <= cmd_wb;
        end
    end

    // ALU drive: always derived from latched fields and current registers.
    // Operands are read combinationally, so an ra==rd self-update sees the old value.
    always_comb begin
        alu_a   = (ra_l == 2'd0) ? 4'd0 : regs[ra_l];
        alu_b   = use_imm_l ? imm_l : ((rb_l == 2'd0) ? 4'd0 : regs[rb_l]);
        alu_op  = op_l;
        rf_data = (rf_addr == 2'd0) ? 4'd0 : regs[rf_addr];
    end

    // Register file write-back at the end of EXEC; R0 writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
        end else if (wr_en) begin
            regs[rd_l] <= alu_result;
        end
    end

    // Response capture at the end of EXEC; held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
        end
    end

    // Saturating count of completed response handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count <= '0;
        end else if (rsp_fire && (cmd_count != {CNT_W{1'b1}})) begin
            cmd_count <= cmd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
// A second instance with CNT_W=2 shares all stimulus to exercise counter saturation.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [1:0] cmd_ra = 2'd0, cmd_rb = 2'd0, cmd_rd = 2'd0;
    logic [3:0] cmd_imm = 4'd0;
    logic       cmd_use_imm = 1'b0, cmd_wb = 1'b0;
    logic       rsp_ready = 1'b1;
    logic [1:0] rf_addr = 2'd0;

    logic       cmd_ready, rsp_valid, rsp_carry, rsp_zero;
    logic [3:0] alu_a, alu_b, alu_result, rsp_result, rf_data;
    logic [2:0] alu_op;
    logic       alu_carry, alu_zero;
    logic [7:0] cmd_count;

    logic       cmd_ready2, rsp_valid2, rsp_carry2, rsp_zero2;
    logic [3:0] alu_a2, alu_b2, alu_result2, rsp_result2, rf_data2;
    logic [2:0] alu_op2;
    logic       alu_carry2, alu_zero2;
    logic [1:0] cmd_count2;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

    // ALU behaviour: returns {carry, result}. SUB carry is the borrow.
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int s;
        case (op)
            OP_ADD: begin s = int'(a) + int'(b); return {s >= 16, 4'(s)}; end
            OP_SUB: begin s = int'(a) - int'(b); return {s < 0, 4'(s + 16)}; end
            OP_AND: return {1'b0, a & b};
            OP_OR:  return {1'b0, a | b};
            OP_XOR: return {1'b0, a ^ b};
            OP_NOT: return {1'b0, ~a};
            OP_SHL: begin s = int'(a) * 2; return {s >= 16, 4'(s)}; end
            default: return {a[0], 4'(int'(a) / 2)};
        endcase
    endfunction

    assign {alu_carry, alu_result}   = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero                  = (alu_result == 4'd0);
    assign {alu_carry2, alu_result2} = alu_fn(alu_op2, alu_a2, alu_b2);
    assign alu_zero2                 = (alu_result2 == 4'd0);

    alu_cmd_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_wb(cmd_wb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rf_addr(rf_addr), .rf_data(rf_data), .cmd_count(cmd_count)
    );

    alu_cmd_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_wb(cmd_wb),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2),
        .alu_result(alu_result2), .alu_carry(alu_carry2), .alu_zero(alu_zero2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_carry(rsp_carry2), .rsp_zero(rsp_zero2),
        .rf_addr(rf_addr), .rf_data(rf_data2), .cmd_count(cmd_count2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] m_reg [4];
    int m_count = 0;
    logic [5:0] exp_q [$];   // {zero, carry, result}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
        m_count = 0;
        exp_q.delete();
    endtask

    // Per-cycle compare of response channel and counters against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_count", 32'(cmd_count), 32'(m_count));
            chk("cmd_count_sat", 32'(cmd_count2), 32'((m_count > 3) ? 3 : m_count));
            chk("dut2_rsp_valid", 32'(rsp_valid2), 32'(rsp_valid));
            if (rsp_valid) begin
                chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_result", 32'(rsp_result), 32'(exp_q[0][3:0]));
                    chk("rsp_carry", 32'(rsp_carry), 32'(exp_q[0][4]));
                    chk("rsp_zero", 32'(rsp_zero), 32'(exp_q[0][5]));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        if (m_count < 255) m_count++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge where rsp_valid must first be high.
    task automatic send(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic [3:0] imm, input logic use_imm,
                        input logic wb);
        int t = 0;
        logic [3:0] a_e, b_e;
        logic [4:0] r;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        chk("accept_timeout", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        cmd_imm = imm; cmd_use_imm = use_imm; cmd_wb = wb; cmd_valid = 1'b1;
        @(posedge clk);
        a_e = m_reg[ra];
        b_e = use_imm ? imm : m_reg[rb];
        r = alu_fn(op, a_e, b_e);
        exp_q.push_back({r[3:0] == 4'd0, r[4], r[3:0]});
        if (wb && rd != 2'd0) m_reg[rd] = r[3:0];
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_a", 32'(alu_a), 32'(a_e));
        chk("exec_alu_b", 32'(alu_b), 32'(b_e));
        chk("exec_alu_op", 32'(alu_op), 32'(op));
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_latency", 32'(rsp_valid), 32'd1);
    endtask

    task automatic lit_rsp(input string name, input logic [3:0] res, input logic c, input logic z);
        chk({name, "_result"}, 32'(rsp_result), 32'(res));
        chk({name, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({name, "_zero"}, 32'(rsp_zero), 32'(z));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        chk("idle_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rf_addr = 2'(i);
            #1;
            chk({tag, "_rf"}, 32'(rf_data), 32'(m_reg[i]));
            chk({tag, "_rf2"}, 32'(rf_data2), 32'(m_reg[i]));
        end
    endtask

    task automatic lit_reg(input string name, input logic [1:0] idx, input logic [3:0] val);
        rf_addr = idx;
        #1;
        chk(name, 32'(rf_data), 32'(val));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp", 32'({rsp_zero, rsp_carry, rsp_result}), 32'd0);
        chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        chk("rst_count", 32'(cmd_count), 32'd0);
        check_regs("rst");

        // Load then overflow.
        send(OP_ADD, 2'd0, 2'd0, 2'd1, 4'd9, 1'b1, 1'b1);
        lit_rsp("load", 4'd9, 1'b0, 1'b0);
        send(OP_ADD, 2'd1, 2'd0, 2'd2, 4'd7, 1'b1, 1'b1);
        lit_rsp("ovf", 4'd0, 1'b1, 1'b1);
        wait_idle();
        lit_reg("ovf_r1", 2'd1, 4'd9);
        lit_reg("ovf_r2", 2'd2, 4'd0);
        chk("ovf_count", 32'(cmd_count), 32'd2);

        // Shift and self-update.
        send(OP_SHL, 2'd1, 2'd0, 2'd1, 4'd0, 1'b1, 1'b1);
        lit_rsp("shl", 4'd2, 1'b1, 1'b0);
        send(OP_SHR, 2'd1, 2'd0, 2'd1, 4'd0, 1'b1, 1'b1);
        lit_rsp("shr", 4'd1, 1'b0, 1'b0);
        wait_idle();
        lit_reg("shr_r1", 2'd1, 4'd1);

        // Write suppression.
        send(OP_ADD, 2'd0, 2'd0, 2'd1, 4'd5, 1'b1, 1'b1);
        send(OP_XOR, 2'd1, 2'd0, 2'd0, 4'd3, 1'b1, 1'b1);
        lit_rsp("xor", 4'd6, 1'b0, 1'b0);
        send(OP_AND, 2'd1, 2'd0, 2'd1, 4'd3, 1'b1, 1'b0);
        wait_idle();
        lit_reg("wsup_r0", 2'd0, 4'd0);
        lit_reg("wsup_r1", 2'd1, 4'd5);
        check_regs("wsup");

        // Backpressure: SUB 5-7 wraps to 14 with borrow.
        rsp_ready = 1'b0;
        send(OP_SUB, 2'd1, 2'd0, 2'd2, 4'd7, 1'b1, 1'b1);
        lit_rsp("sub", 4'd14, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 1);
            cmd_op = OP_OR; cmd_rd = 2'd3; cmd_imm = 4'd15;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        chk("bp_count_held", 32'(cmd_count), 32'd7);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_count", 32'(cmd_count), 32'd8);
        check_regs("bp");

        // Register-sourced operands: OR 5|14 and NOT 5.
        send(OP_OR, 2'd1, 2'd2, 2'd3, 4'd0, 1'b0, 1'b1);
        lit_rsp("or_reg", 4'd15, 1'b0, 1'b0);
        send(OP_NOT, 2'd1, 2'd0, 2'd0, 4'd0, 1'b1, 1'b1);
        lit_rsp("not", 4'd10, 1'b0, 1'b0);
        wait_idle();
        check_regs("regsrc");

        // Reset during EXEC aborts the command.
        cmd_op = OP_ADD; cmd_ra = 2'd0; cmd_rd = 2'd3; cmd_imm = 4'd4;
        cmd_use_imm = 1'b1; cmd_wb = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        lit_reg("abort_r3", 2'd3, 4'd0);
        chk("abort_count", 32'(cmd_count), 32'd0);

        // Five commands: wide counter reaches 5, the 2-bit one saturates at 3.
        for (int i = 0; i < 5; i++) begin
            send(OP_ADD, 2'd3, 2'd0, 2'd3, 4'd1, 1'b1, 1'b1);
        end
        wait_idle();
        chk("sat_count8", 32'(cmd_count), 32'd5);
        chk("sat_count2", 32'(cmd_count2), 32'd3);
        lit_reg("sat_r3", 2'd3, 4'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
